// File: rtl/display_pkg.sv
// Shared constants, FSM state type and slice helper for the display scheduler.
// Also used by other shared-resource arbiters in the system.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam int DEFAULT_HOLD = 50_000_000;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  function automatic int slice_off(
    input int k,
    input int digits,
    input int w
  );
    return k * digits * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester strictly after last.
// last itself wins only when it is the sole requester.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any_req
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] j;
  logic          found;

  assign any_req = |req;

  // Scan last+1 .. last+N; the final step lands on last itself.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 1; i <= N; i++) begin
      j = IW'((int'(last) + i) % N);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin time-share of the hex display bank with a fixed dwell.
// Define DISPLAY_SCHED_LIVE_EN to pass the granted word through live.
module display_scheduler
  import display_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int W           = 4,
  parameter int DIGITS      = 4,
  parameter int HOLD_CYCLES = DEFAULT_HOLD
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic [N_SRC-1:0]            i_Valid,
  input  logic [N_SRC*DIGITS*W-1:0]   i_Data,
  input  logic                        i_Pause,
  output logic [DIGITS*W-1:0]         o_Digits,
  output logic                        o_Blank,
  output logic [N_SRC-1:0]            o_Sel,
  output logic [$clog2(N_SRC)-1:0]    o_Src,
  output logic [N_SRC-1:0]            o_Ack
);

  localparam int SW = $clog2(N_SRC);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam int DW = DIGITS * W;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     last_q, last_d;
  logic [SW-1:0]     src_q, src_d;
  logic [N_SRC-1:0]  sel_q, sel_d;
  logic [N_SRC-1:0]  ack_q, ack_d;
  logic              blank_q, blank_d;

  logic [N_SRC-1:0]  win_gnt;
  logic [SW-1:0]     win_idx;
  logic              any_v;
  logic [DW-1:0]     win_word;
  logic              dwell_end;
  logic              take;
  logic              drop;

  rr_arbiter #(
    .N(N_SRC)
  ) u_arb (
    .req    (i_Valid),
    .last   (last_q),
    .grant  (win_gnt),
    .idx    (win_idx),
    .any_req(any_v)
  );

  always_comb begin
    win_word = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (win_idx == SW'(k))
        win_word = i_Data[slice_off(k, DIGITS, W) +: DW];
    end
  end

  assign dwell_end = (state_q == SHOW) && !i_Pause &&
                     (cnt_q == CW'(HOLD_CYCLES - 1));
  assign take = any_v && ((state_q == IDLE) || dwell_end);
  assign drop = dwell_end && !any_v;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_v) state_d = SHOW;
      SHOW: if (drop)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    src_d   = src_q;
    sel_d   = sel_q;
    blank_d = blank_q;
    ack_d   = '0;
    if (take) begin
      cnt_d   = '0;
      last_d  = win_idx;
      src_d   = win_idx;
      sel_d   = win_gnt;
      blank_d = 1'b0;
      ack_d   = win_gnt;
    end else if (drop) begin
      cnt_d   = '0;
      src_d   = '0;
      sel_d   = '0;
      blank_d = 1'b1;
    end else if ((state_q == SHOW) && !i_Pause) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cnt_q   <= '0;
      last_q  <= SW'(N_SRC - 1);
      src_q   <= '0;
      sel_q   <= '0;
      ack_q   <= '0;
      blank_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      src_q   <= src_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      blank_q <= blank_d;
    end
  end

  assign o_Blank = blank_q;
  assign o_Sel   = sel_q;
  assign o_Src   = src_q;
  assign o_Ack   = ack_q;

`ifdef DISPLAY_SCHED_LIVE_EN
  always_comb begin
    o_Digits = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!blank_q && (src_q == SW'(k)))
        o_Digits = i_Data[slice_off(k, DIGITS, W) +: DW];
    end
  end
`else
  logic [DW-1:0] digits_q;

  // Snapshot only at grant; held through the dwell and into idle.
  always_ff @(posedge i_Clock) begin
    if (i_Reset)   digits_q <= '0;
    else if (take) digits_q <= win_word;
  end

  assign o_Digits = digits_q;
`endif

endmodule

// File: tb/tb_display_scheduler.sv
// Table vectors, hand-written corner sequences and a random run
// against a dwell-countdown reference model of the scheduler.
module tb_display_scheduler;

  localparam int N  = 4;
  localparam int DG = 2;
  localparam int WW = 4;
  localparam int HC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [7:0]  o_digits;
  logic        o_blank;
  logic [3:0]  o_sel;
  logic [1:0]  o_src;
  logic [3:0]  o_ack;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  display_scheduler #(
    .N_SRC      (N),
    .W          (WW),
    .DIGITS     (DG),
    .HOLD_CYCLES(HC)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .i_Valid (valid),
    .i_Data  (data),
    .i_Pause (pause),
    .o_Digits(o_digits),
    .o_Blank (o_blank),
    .o_Sel   (o_sel),
    .o_Src   (o_src),
    .o_Ack   (o_ack)
  );

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [31:0] d;
    logic        p;
    logic        eb;
    logic [3:0]  esel;
    logic [1:0]  esrc;
    logic [7:0]  edig;
    logic [3:0]  eack;
  } vec_t;

  vec_t tbl[$];

  task automatic step(input logic r, input logic [3:0] v,
                      input logic [31:0] d, input logic p);
    rst   = r;
    valid = v;
    data  = d;
    pause = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic eb,
                     input logic [3:0] esel, input logic [1:0] esrc,
                     input logic [7:0] edig, input logic [3:0] eack);
    n_vec++;
    if ({o_blank, o_sel, o_src, o_digits, o_ack} !==
        {eb, esel, esrc, edig, eack}) begin
      n_err++;
      $display("FAIL %s: got blank=%b sel=%b src=%0d dig=%h ack=%b, want blank=%b sel=%b src=%0d dig=%h ack=%b",
               nm, o_blank, o_sel, o_src, o_digits, o_ack,
               eb, esel, esrc, edig, eack);
    end
  endtask

  task automatic sv(input string nm, input logic r,
                    input logic [3:0] v, input logic [31:0] d,
                    input logic p, input logic eb,
                    input logic [3:0] esel, input logic [1:0] esrc,
                    input logic [7:0] edig, input logic [3:0] eack);
    step(r, v, d, p);
    chk(nm, eb, esel, esrc, edig, eack);
  endtask

  // Reference model: owner (-1 idle), unpaused cycles left in dwell.
  int          m_own;
  int          m_left;
  int          m_last;
  logic [7:0]  m_snap;
  logic        m_ack;

  function automatic int pick(input logic [3:0] v, input int last);
    for (int i = 1; i <= N; i++)
      if (v[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_own  = -1;
    m_left = 0;
    m_last = N - 1;
    m_snap = 8'h00;
    m_ack  = 1'b0;
  endtask

  task automatic model_grant(input logic [3:0] v, input logic [31:0] d);
    m_own  = pick(v, m_last);
    m_last = m_own;
    m_snap = d[m_own*8 +: 8];
    m_left = HC;
    m_ack  = 1'b1;
  endtask

  task automatic model_step(input logic r, input logic [3:0] v,
                            input logic [31:0] d, input logic p);
    if (r) begin
      model_reset();
    end else begin
      m_ack = 1'b0;
      if (m_own < 0) begin
        if (v != 4'b0) model_grant(v, d);
      end else if (!p) begin
        m_left--;
        if (m_left == 0) begin
          if (v != 4'b0) model_grant(v, d);
          else           m_own = -1;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  rv;
    logic [3:0]  msel;
    vec_t        t;
    int          g;

    rst   = 1'b1;
    valid = 4'b0;
    data  = 32'h0;
    pause = 1'b0;

    t = '{r:1'b1, v:4'b0, d:32'h0, p:1'b0, eb:1'b1,
          esel:4'b0, esrc:2'd0, edig:8'h00, eack:4'b0};
    tbl.push_back(t);
    for (int i = 0; i < 10; i++) begin
      t.r = 1'b0;
      tbl.push_back(t);
    end
    for (int i = 0; i < 20; i++) begin
      g      = (i / HC) % N;
      t.r    = 1'b0;
      t.v    = 4'b1111;
      t.d    = 32'h3322_1100;
      t.eb   = 1'b0;
      t.esel = 4'(1 << g);
      t.esrc = 2'(g);
      t.edig = 8'(g * 8'h11);
      t.eack = (i % HC == 0) ? 4'(1 << g) : 4'b0;
      tbl.push_back(t);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].p);
      chk($sformatf("tbl[%0d]", i), tbl[i].eb, tbl[i].esel,
          tbl[i].esrc, tbl[i].edig, tbl[i].eack);
    end

    // Source 2 alone; its word changes mid-dwell.
    sv("a_rst", 1, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 4'b0000);
    sv("a_g",   0, 4'b0100, 32'h00A5_0000, 0,
       0, 4'b0100, 2, 8'hA5, 4'b0100);
    for (int i = 1; i < HC; i++)
      sv("a_hold", 0, 4'b0100, 32'h005A_0000, 0,
         0, 4'b0100, 2, 8'hA5, 4'b0000);
    sv("a_regr", 0, 4'b0100, 32'h005A_0000, 0,
       0, 4'b0100, 2, 8'h5A, 4'b0100);
    sv("a_after", 0, 4'b0100, 32'h005A_0000, 0,
       0, 4'b0100, 2, 8'h5A, 4'b0000);

    // Source 1 paused for 6 cycles at cnt=2.
    sv("b_rst", 1, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 4'b0000);
    sv("b_g",  0, 4'b0010, 32'h3322_1100, 0,
       0, 4'b0010, 1, 8'h11, 4'b0010);
    sv("b_c1", 0, 4'b0011, 32'h3322_1100, 0,
       0, 4'b0010, 1, 8'h11, 4'b0000);
    sv("b_c2", 0, 4'b0011, 32'h3322_1100, 0,
       0, 4'b0010, 1, 8'h11, 4'b0000);
    for (int i = 0; i < 6; i++)
      sv("b_pause", 0, 4'b0011, 32'h3322_1100, 1,
         0, 4'b0010, 1, 8'h11, 4'b0000);
    sv("b_c3", 0, 4'b0011, 32'h3322_1100, 0,
       0, 4'b0010, 1, 8'h11, 4'b0000);
    sv("b_regr", 0, 4'b0011, 32'h3322_1100, 0,
       0, 4'b0001, 0, 8'h00, 4'b0001);

    // Source 3 loses valid mid-dwell, then idle.
    sv("c_rst", 1, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 4'b0000);
    sv("c_g",  0, 4'b1000, 32'h3322_1100, 0,
       0, 4'b1000, 3, 8'h33, 4'b1000);
    for (int i = 1; i < HC; i++)
      sv("c_hold", 0, 4'b0000, 32'h3322_1100, 0,
         0, 4'b1000, 3, 8'h33, 4'b0000);
    sv("c_idle", 0, 4'b0000, 32'h3322_1100, 0,
       1, 4'b0000, 0, 8'h33, 4'b0000);
    sv("c_idle2", 0, 4'b0000, 32'h3322_1100, 0,
       1, 4'b0000, 0, 8'h33, 4'b0000);

    // Reset at cnt=1 of source 2.
    sv("d_rst", 1, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 8'h00, 4'b0000);
    sv("d_g",  0, 4'b0100, 32'h3322_1100, 0,
       0, 4'b0100, 2, 8'h22, 4'b0100);
    sv("d_c1", 0, 4'b0100, 32'h3322_1100, 0,
       0, 4'b0100, 2, 8'h22, 4'b0000);
    sv("d_mid", 1, 4'b1111, 32'h3322_1100, 1,
       1, 4'b0000, 0, 8'h00, 4'b0000);
    sv("d_low", 0, 4'b0110, 32'h3322_1100, 0,
       0, 4'b0010, 1, 8'h11, 4'b0010);

    // Randomized run against the reference model.
    step(1'b1, 4'b0, 32'h0, 1'b0);
    model_reset();
    for (int i = 0; i < 800; i++) begin
      logic r;
      logic p;
      rd = $urandom;
      rv = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rv = 4'b0;
      p  = ($urandom_range(0, 4) == 0);
      r  = ($urandom_range(0, 59) == 0);
      step(r, rv, rd, p);
      model_step(r, rv, rd, p);
      msel = (m_own < 0) ? 4'b0 : 4'(1 << m_own);
      chk($sformatf("rand[%0d]", i), m_own < 0, msel,
          (m_own < 0) ? 2'd0 : 2'(m_own), m_snap,
          m_ack ? msel : 4'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
